// File: rtl/npc_multicycle_sequencer.sv
// Multi-cycle fetch/decode/exec/mem/writeback sequencer with cycle/instret counters and sticky halt.
// Latency: 5 cycles per ALU instruction, 7 per load/store with zero-wait buses; strobes are Moore outputs.
// Backpressure: request valids hold until ready; waits are bounded by TIMEOUT, expiry halts with code 2.
module npc_multicycle_sequencer #(
   parameter int CNT_W   = 64,
   parameter int TIMEOUT = 255,
   parameter int TO_W    = 8
) (
   input  logic             clk,
   input  logic             rst,
   output logic             ifu_req_valid,
   input  logic             ifu_req_ready,
   input  logic             ifu_rsp_valid,
   input  logic [31:0]      ifu_rsp_inst,
   output logic [31:0]      inst_q,
   input  logic             dec_RegWr,
   input  logic             dec_MemtoReg,
   input  logic             dec_MemWr,
   input  logic             dec_illegal,
   output logic             lsu_req_valid,
   output logic             lsu_req_we,
   input  logic             lsu_req_ready,
   input  logic             lsu_rsp_valid,
   output logic             pc_we,
   output logic             rf_we,
   output logic             halt,
   output logic [1:0]       halt_code,
   output logic [CNT_W-1:0] cycle_cnt,
   output logic [CNT_W-1:0] instret
);

   typedef enum logic [3:0] {
      S_IDLE,
      S_FETCH_REQ,
      S_FETCH_WAIT,
      S_DECODE,
      S_EXEC,
      S_MEM_REQ,
      S_MEM_WAIT,
      S_WB,
      S_HALT
   } state_t;

   localparam logic [31:0]     EBREAK     = 32'h0010_0073;
   localparam logic [1:0]      HC_EBREAK  = 2'd0;
   localparam logic [1:0]      HC_ILLEGAL = 2'd1;
   localparam logic [1:0]      HC_TIMEOUT = 2'd2;
   localparam bit              TO_EN      = (TIMEOUT != 0);
   // Counter holds the number of stalled cycles already spent; the cycle that
   // would be the TIMEOUT-th stall is the one that triggers the halt.
   localparam logic [TO_W-1:0] TO_LAST    = TO_W'(TIMEOUT - 1);

   state_t          state;
   state_t          state_nx;
   logic [1:0]      halt_src;
   logic            in_wait;
   logic            exit_cond;
   logic [TO_W-1:0] wait_cnt;

   // Next-state selection and Moore strobe decode from the current state.
   always_comb begin
      state_nx      = state;
      halt_src      = HC_EBREAK;
      in_wait       = 1'b0;
      exit_cond     = 1'b0;
      ifu_req_valid = 1'b0;
      lsu_req_valid = 1'b0;
      lsu_req_we    = 1'b0;
      pc_we         = 1'b0;
      rf_we         = 1'b0;
      case (state)
         S_IDLE: begin
            state_nx = S_FETCH_REQ;
         end
         S_FETCH_REQ: begin
            ifu_req_valid = 1'b1;
            in_wait       = 1'b1;
            exit_cond     = ifu_req_ready;
            if (ifu_req_ready) state_nx = S_FETCH_WAIT;
         end
         S_FETCH_WAIT: begin
            in_wait   = 1'b1;
            exit_cond = ifu_rsp_valid;
            if (ifu_rsp_valid) state_nx = S_DECODE;
         end
         S_DECODE: begin
            state_nx = S_EXEC;
         end
         S_EXEC: begin
            if (inst_q == EBREAK) begin
               state_nx = S_HALT;
               halt_src = HC_EBREAK;
            end else if (dec_illegal) begin
               state_nx = S_HALT;
               halt_src = HC_ILLEGAL;
            end else if (dec_MemtoReg || dec_MemWr) begin
               state_nx = S_MEM_REQ;
            end else begin
               state_nx = S_WB;
            end
         end
         S_MEM_REQ: begin
            // inst_q is frozen here, so dec_MemWr is stable for the whole request.
            lsu_req_valid = 1'b1;
            lsu_req_we    = dec_MemWr;
            in_wait       = 1'b1;
            exit_cond     = lsu_req_ready;
            if (lsu_req_ready) state_nx = S_MEM_WAIT;
         end
         S_MEM_WAIT: begin
            in_wait   = 1'b1;
            exit_cond = lsu_rsp_valid;
            if (lsu_rsp_valid) state_nx = S_WB;
         end
         S_WB: begin
            pc_we    = 1'b1;
            rf_we    = dec_RegWr;
            state_nx = S_FETCH_REQ;
         end
         S_HALT: begin
            state_nx = S_HALT;
         end
         default: begin
            state_nx = S_IDLE;
         end
      endcase
      // A handshake completing in the last allowed cycle still wins.
      if (TO_EN && in_wait && !exit_cond && (wait_cnt == TO_LAST)) begin
         state_nx = S_HALT;
         halt_src = HC_TIMEOUT;
      end
   end

   // State, instruction latch, wait timer, counters and sticky halt record.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         inst_q    <= 32'h0;
         wait_cnt  <= '0;
         cycle_cnt <= '0;
         instret   <= '0;
         halt      <= 1'b0;
         halt_code <= 2'd0;
      end else begin
         state     <= state_nx;
         cycle_cnt <= cycle_cnt + CNT_W'(1);
         if (state == S_WB) begin
            instret <= instret + CNT_W'(1);
         end
         if ((state == S_FETCH_WAIT) && ifu_rsp_valid) begin
            inst_q <= ifu_rsp_inst;
         end
         if (state_nx != state) begin
            wait_cnt <= '0;
         end else if (in_wait) begin
            wait_cnt <= wait_cnt + TO_W'(1);
         end
         if ((state_nx == S_HALT) && (state != S_HALT)) begin
            halt      <= 1'b1;
            halt_code <= halt_src;
         end
      end
   end

endmodule
